// File: rtl/mac_lookup_requester.sv
// ---------------------------------------------------------------------------
// mac_lookup_requester
//   Ingress-side initiator for the switch MAC lookup/learning table. Parses
//   DA (bytes 0-5) and SA (bytes 6-11) from the ingress byte stream, issues
//   one lookup+learn request per frame, waits for the table response, emits
//   a per-frame forwarding decision and then drains the rest of the frame.
//
// Optional feature macro: MAC_REQ_TIMEOUT_EN
//   defined   : WAIT is bounded by TIMEOUT_CYCLES; on expiry the lookup is
//               treated as a miss (flood) and o_timeout_err pulses.
//   undefined : WAIT lasts until a response arrives; o_timeout_err tied 0.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   i_rx_*/o_rx_ready   ingress byte stream (valid/ready, sof/eof, port)
//   o_req_*/i_req_ready lookup request (DA, SA, ingress port)
//   i_rsp_*             single-cycle lookup response strobe
//   o_fwd_*/i_fwd_ready forwarding decision (mask, flood flag)
//   o_runt_drop         1-cycle pulse: frame ended inside the header
//   o_timeout_err       1-cycle pulse: lookup response timed out
// ---------------------------------------------------------------------------
module mac_lookup_requester #(
  parameter int ADDR_WIDTH     = 48,
  parameter int PORTS          = 16,
  parameter int PORT_W         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_sof,
  input  logic                  i_rx_eof,
  input  logic [PORT_W-1:0]     i_rx_port,
  output logic                  o_rx_ready,
  output logic                  o_req_valid,
  input  logic                  i_req_ready,
  output logic [ADDR_WIDTH-1:0] o_req_dst_mac,
  output logic [ADDR_WIDTH-1:0] o_req_src_mac,
  output logic [PORT_W-1:0]     o_req_in_port,
  input  logic                  i_rsp_valid,
  input  logic                  i_rsp_found,
  input  logic [PORT_W-1:0]     i_rsp_port,
  output logic                  o_fwd_valid,
  input  logic                  i_fwd_ready,
  output logic [PORTS-1:0]      o_fwd_mask,
  output logic                  o_fwd_flood,
  output logic                  o_runt_drop,
  output logic                  o_timeout_err
);

  localparam int HDR_W     = 2 * ADDR_WIDTH;
  localparam int HDR_BYTES = HDR_W / 8;
  localparam int CNT_W     = $clog2(HDR_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(HDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_FWD   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [HDR_W-1:0]   r_hdr, w_hdr;
  logic [PORT_W-1:0]  r_in_port, w_in_port;
  logic               r_eof_seen, w_eof_seen;
  logic [PORTS-1:0]   r_fwd_mask, w_fwd_mask;
  logic               r_fwd_flood, w_fwd_flood;
  logic               r_runt_drop, w_runt_drop;
  logic               r_timeout_err, w_timeout_err;
  logic               r_rx_ready, w_rx_ready;
  logic               r_req_valid, w_req_valid;
  logic               r_fwd_valid, w_fwd_valid;

  logic                  w_beat;
  logic                  w_start;
  logic                  w_resolve;
  logic                  w_found;
  logic                  w_mcast;
  logic [ADDR_WIDTH-1:0] w_da;

`ifdef MAC_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt, w_to_cnt;
`endif

  // Next-state, datapath and registered-output decode for the frame FSM
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_hdr         = r_hdr;
    w_in_port     = r_in_port;
    w_eof_seen    = r_eof_seen;
    w_fwd_mask    = r_fwd_mask;
    w_fwd_flood   = r_fwd_flood;
    w_runt_drop   = 1'b0;
    w_timeout_err = 1'b0;
    w_start       = 1'b0;
    w_resolve     = 1'b0;
    w_found       = 1'b0;
    w_beat        = i_rx_valid & r_rx_ready;
    w_da          = r_hdr[HDR_W-1:ADDR_WIDTH];
    // Broadcast is all-ones; group bit is the LSB of the first DA byte.
    w_mcast       = (&w_da) | w_da[ADDR_WIDTH-8];
`ifdef MAC_REQ_TIMEOUT_EN
    w_to_cnt      = r_to_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_beat && i_rx_sof) begin
          w_start = 1'b1;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_HDR: begin
        if (w_beat && i_rx_sof) begin
          w_start = 1'b1;
        end else if (w_beat) begin
          w_hdr = {r_hdr[HDR_W-9:0], i_rx_data};
          if (r_cnt == LAST_BYTE) begin
            w_state    = S_REQ;
            w_eof_seen = i_rx_eof;
          end else if (i_rx_eof) begin
            w_state     = S_IDLE;
            w_runt_drop = 1'b1;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state = S_HDR;
        end
      end
      S_REQ: begin
        if (i_req_ready) begin
          w_state = S_WAIT;
`ifdef MAC_REQ_TIMEOUT_EN
          w_to_cnt = '0;
`endif
        end else begin
          w_state = S_REQ;
        end
      end
      S_WAIT: begin
        if (i_rsp_valid) begin
          w_resolve = 1'b1;
          w_found   = i_rsp_found;
          w_state   = S_FWD;
        end else begin
`ifdef MAC_REQ_TIMEOUT_EN
          // Expiry counts as a miss; a same-cycle response took the branch above.
          if (r_to_cnt == TO_LAST) begin
            w_resolve     = 1'b1;
            w_found       = 1'b0;
            w_timeout_err = 1'b1;
            w_state       = S_FWD;
          end else begin
            w_to_cnt = r_to_cnt + TO_W'(1);
          end
`else
          w_state = S_WAIT;
`endif
        end
      end
      S_FWD: begin
        if (i_fwd_ready) begin
          w_state = r_eof_seen ? S_IDLE : S_DRAIN;
        end else begin
          w_state = S_FWD;
        end
      end
      S_DRAIN: begin
        if (w_beat && i_rx_sof) begin
          w_start = 1'b1;
        end else if (w_beat && i_rx_eof) begin
          w_state = S_IDLE;
        end else begin
          w_state = S_DRAIN;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // A SOF beat always opens a new header, whatever was in progress.
    if (w_start) begin
      w_hdr       = {{(HDR_W-8){1'b0}}, i_rx_data};
      w_cnt       = CNT_W'(1);
      w_in_port   = i_rx_port;
      w_runt_drop = i_rx_eof;
      w_state     = i_rx_eof ? S_IDLE : S_HDR;
    end else begin
      w_cnt = w_cnt;
    end

    if (w_resolve) begin
      if (w_mcast || !w_found) begin
        w_fwd_mask  = ~(PORTS'(1) << r_in_port);
        w_fwd_flood = 1'b1;
      end else if (i_rsp_port == r_in_port) begin
        w_fwd_mask  = '0;
        w_fwd_flood = 1'b0;
      end else begin
        w_fwd_mask  = PORTS'(1) << i_rsp_port;
        w_fwd_flood = 1'b0;
      end
    end else begin
      w_fwd_mask = w_fwd_mask;
    end

    w_rx_ready  = (w_state == S_IDLE) || (w_state == S_HDR) || (w_state == S_DRAIN);
    w_req_valid = (w_state == S_REQ);
    w_fwd_valid = (w_state == S_FWD);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_hdr         <= '0;
      r_in_port     <= '0;
      r_eof_seen    <= 1'b0;
      r_fwd_mask    <= '0;
      r_fwd_flood   <= 1'b0;
      r_runt_drop   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rx_ready    <= 1'b0;
      r_req_valid   <= 1'b0;
      r_fwd_valid   <= 1'b0;
`ifdef MAC_REQ_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_hdr         <= w_hdr;
      r_in_port     <= w_in_port;
      r_eof_seen    <= w_eof_seen;
      r_fwd_mask    <= w_fwd_mask;
      r_fwd_flood   <= w_fwd_flood;
      r_runt_drop   <= w_runt_drop;
      r_timeout_err <= w_timeout_err;
      r_rx_ready    <= w_rx_ready;
      r_req_valid   <= w_req_valid;
      r_fwd_valid   <= w_fwd_valid;
`ifdef MAC_REQ_TIMEOUT_EN
      r_to_cnt      <= w_to_cnt;
`endif
    end
  end

  assign o_rx_ready    = r_rx_ready;
  assign o_req_valid   = r_req_valid;
  assign o_req_dst_mac = r_hdr[HDR_W-1:ADDR_WIDTH];
  assign o_req_src_mac = r_hdr[ADDR_WIDTH-1:0];
  assign o_req_in_port = r_in_port;
  assign o_fwd_valid   = r_fwd_valid;
  assign o_fwd_mask    = r_fwd_mask;
  assign o_fwd_flood   = r_fwd_flood;
  assign o_runt_drop   = r_runt_drop;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mac_lookup_requester.sv
// ---------------------------------------------------------------------------
// tb_mac_lookup_requester
//   Directed-vector bench for mac_lookup_requester. Frames are driven
//   through the ingress stream, the table side is played by hand, and every
//   observed output is checked against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mac_lookup_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        i_rx_sof;
  logic        i_rx_eof;
  logic [3:0]  i_rx_port;
  logic        o_rx_ready;
  logic        o_req_valid;
  logic        i_req_ready;
  logic [47:0] o_req_dst_mac;
  logic [47:0] o_req_src_mac;
  logic [3:0]  o_req_in_port;
  logic        i_rsp_valid;
  logic        i_rsp_found;
  logic [3:0]  i_rsp_port;
  logic        o_fwd_valid;
  logic        i_fwd_ready;
  logic [15:0] o_fwd_mask;
  logic        o_fwd_flood;
  logic        o_runt_drop;
  logic        o_timeout_err;

  int n_vec   = 0;
  int n_err   = 0;
  int n_stall = 0;

  always #5 clk = ~clk;

  mac_lookup_requester dut (
    .clk           (clk),
    .reset         (reset),
    .i_rx_valid    (i_rx_valid),
    .i_rx_data     (i_rx_data),
    .i_rx_sof      (i_rx_sof),
    .i_rx_eof      (i_rx_eof),
    .i_rx_port     (i_rx_port),
    .o_rx_ready    (o_rx_ready),
    .o_req_valid   (o_req_valid),
    .i_req_ready   (i_req_ready),
    .o_req_dst_mac (o_req_dst_mac),
    .o_req_src_mac (o_req_src_mac),
    .o_req_in_port (o_req_in_port),
    .i_rsp_valid   (i_rsp_valid),
    .i_rsp_found   (i_rsp_found),
    .i_rsp_port    (i_rsp_port),
    .o_fwd_valid   (o_fwd_valid),
    .i_fwd_ready   (i_fwd_ready),
    .o_fwd_mask    (o_fwd_mask),
    .o_fwd_flood   (o_fwd_flood),
    .o_runt_drop   (o_runt_drop),
    .o_timeout_err (o_timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One ingress beat; waits (bounded) for rx_ready, returns after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic sof, input logic eof);
    i_rx_valid = 1'b1;
    i_rx_data  = d;
    i_rx_sof   = sof;
    i_rx_eof   = eof;
    for (int i = 0; i < 200 && !o_rx_ready; i++) begin
      tick();
      n_stall++;
    end
    if (!o_rx_ready) chk("rx_ready_wait", 64'(o_rx_ready), 64'd1);
    tick();
  endtask

  task automatic rx_idle();
    i_rx_valid = 1'b0;
    i_rx_sof   = 1'b0;
    i_rx_eof   = 1'b0;
  endtask

  task automatic send_hdr(input logic [3:0] port, input logic [47:0] da,
                          input logic [47:0] sa, input logic last_eof);
    logic [95:0] hdr;
    hdr       = {da, sa};
    i_rx_port = port;
    for (int i = 0; i < 12; i++) begin
      send_beat(hdr[95-8*i -: 8], (i == 0), last_eof && (i == 11));
    end
    rx_idle();
    chk("req_valid_latency", 64'(o_req_valid), 64'd1);
    chk("req_dst_mac", 64'(o_req_dst_mac), 64'(da));
    chk("req_src_mac", 64'(o_req_src_mac), 64'(sa));
    chk("req_in_port", 64'(o_req_in_port), 64'(port));
    chk("rx_ready_in_req", 64'(o_rx_ready), 64'd0);
  endtask

  task automatic issue_req();
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    chk("req_once", 64'(o_req_valid), 64'd0);
  endtask

  task automatic respond(input logic found, input logic [3:0] port);
    i_rsp_valid = 1'b1;
    i_rsp_found = found;
    i_rsp_port  = port;
    tick();
    i_rsp_valid = 1'b0;
    i_rsp_found = 1'b0;
    chk("fwd_valid_latency", 64'(o_fwd_valid), 64'd1);
  endtask

  task automatic fwd_done(input logic [15:0] exp_mask, input logic exp_flood);
    tick();
    tick();
    chk("fwd_hold", 64'(o_fwd_valid), 64'd1);
    chk("fwd_mask", 64'(o_fwd_mask), 64'(exp_mask));
    chk("fwd_flood", 64'(o_fwd_flood), 64'(exp_flood));
    i_fwd_ready = 1'b1;
    tick();
    i_fwd_ready = 1'b0;
    chk("fwd_release", 64'(o_fwd_valid), 64'd0);
    chk("rx_ready_after_fwd", 64'(o_rx_ready), 64'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      send_beat(8'(i), 1'b0, (i == n - 1));
    end
    rx_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    logic [63:0] agg;
    agg = {o_rx_ready, o_req_valid, o_fwd_valid, o_fwd_flood, o_runt_drop,
           o_timeout_err, o_fwd_mask, o_req_in_port};
    chk({tag, "_ctrl"}, agg, 64'd0);
    chk({tag, "_da"}, 64'(o_req_dst_mac), 64'd0);
    chk({tag, "_sa"}, 64'(o_req_src_mac), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_fwd;
    logic any_to;
    reset       = 1'b1;
    i_rx_valid  = 1'b0;
    i_rx_data   = 8'h00;
    i_rx_sof    = 1'b0;
    i_rx_eof    = 1'b0;
    i_rx_port   = 4'd0;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_found = 1'b0;
    i_rsp_port  = 4'd0;
    i_fwd_ready = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    tick();

    // 1: stray non-SOF beats in IDLE, then a 60-byte frame on port 3 that misses
    send_beat(8'hAA, 1'b0, 1'b0);
    send_beat(8'hBB, 1'b0, 1'b0);
    send_hdr(4'd3, 48'h001122334455, 48'h020000000001, 1'b0);
    issue_req();
    tick();
    tick();
    tick();
    chk("no_fwd_before_rsp", 64'(o_fwd_valid), 64'd0);
    respond(1'b0, 4'd0);
    fwd_done(16'hFFF7, 1'b1);
    n_stall = 0;
    drain(48);
    chk("drain_stalls", 64'(n_stall), 64'd0);
    chk("no_req_in_drain", 64'(o_req_valid), 64'd0);

    // 2: header restarted by a SOF mid-header, stray response in REQ, hit on port 7
    i_rx_port = 4'd9;
    send_beat(8'h11, 1'b1, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'h33, 1'b0, 1'b0);
    send_hdr(4'd3, 48'h001122334455, 48'h020000000002, 1'b0);
    i_rsp_valid = 1'b1;
    i_rsp_found = 1'b1;
    i_rsp_port  = 4'd7;
    tick();
    i_rsp_valid = 1'b0;
    chk("stray_rsp_req_held", 64'(o_req_valid), 64'd1);
    chk("stray_rsp_no_fwd", 64'(o_fwd_valid), 64'd0);
    issue_req();
    respond(1'b1, 4'd7);
    fwd_done(16'h0080, 1'b0);
    drain(4);

    // 3: hit on the ingress port -> filtered; 12-byte frame goes straight to IDLE
    send_hdr(4'd3, 48'h001122334455, 48'h020000000003, 1'b1);
    issue_req();
    respond(1'b1, 4'd3);
    fwd_done(16'h0000, 1'b0);

    // 4: broadcast from port 0 floods even on a hit
    send_hdr(4'd0, 48'hFFFFFFFFFFFF, 48'h020000000004, 1'b0);
    issue_req();
    respond(1'b1, 4'd5);
    fwd_done(16'hFFFE, 1'b1);
    drain(2);

    // 5: multicast (group bit) from port 2 floods even on a hit
    send_hdr(4'd2, 48'h01005E000001, 48'h020000000005, 1'b1);
    issue_req();
    respond(1'b1, 4'd4);
    fwd_done(16'hFFFB, 1'b1);

    // 6: 8-byte runt, then the next SOF parses normally
    i_rx_port = 4'd6;
    for (int i = 0; i < 8; i++) begin
      send_beat(8'(8'h40 + i), (i == 0), (i == 7));
    end
    rx_idle();
    chk("runt_pulse", 64'(o_runt_drop), 64'd1);
    chk("runt_no_req", 64'(o_req_valid), 64'd0);
    tick();
    chk("runt_pulse_end", 64'(o_runt_drop), 64'd0);
    chk("runt_no_req_later", 64'(o_req_valid), 64'd0);
    send_hdr(4'd6, 48'h00AABBCCDDEE, 48'h020000000006, 1'b1);
    issue_req();
    respond(1'b1, 4'd1);
    fwd_done(16'h0002, 1'b0);

    // 7: no response on a port-5 frame
    send_hdr(4'd5, 48'h001122334455, 48'h020000000007, 1'b1);
    issue_req();
    any_fwd = 1'b0;
    any_to  = 1'b0;
`ifdef MAC_REQ_TIMEOUT_EN
    for (int i = 0; i < 63; i++) begin
      tick();
      any_fwd |= o_fwd_valid;
      any_to  |= o_timeout_err;
    end
    chk("no_early_timeout", 64'({any_fwd, any_to}), 64'd0);
    tick();
    chk("timeout_fwd", 64'(o_fwd_valid), 64'd1);
    chk("timeout_err", 64'(o_timeout_err), 64'd1);
    fwd_done(16'hFFDF, 1'b1);
    chk("timeout_err_pulse", 64'(o_timeout_err), 64'd0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      any_fwd |= o_fwd_valid;
      any_to  |= o_timeout_err;
    end
    chk("wait_unbounded", 64'({any_fwd, any_to}), 64'd0);
    respond(1'b0, 4'd0);
    fwd_done(16'hFFDF, 1'b1);
`endif

    // 8: reset asserted while waiting for a response
    send_hdr(4'd5, 48'h001122334455, 48'h020000000008, 1'b1);
    issue_req();
    tick();
    reset = 1'b1;
    #2;
    chk_all_zero("reset_in_wait");
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rx_ready_after_reset", 64'(o_rx_ready), 64'd1);
    chk("no_fwd_after_reset", 64'(o_fwd_valid), 64'd0);
    send_beat(8'h55, 1'b0, 1'b1);
    rx_idle();
    chk("non_sof_ignored", 64'(o_req_valid), 64'd0);
    send_hdr(4'd4, 48'h001122334455, 48'h020000000009, 1'b1);
    issue_req();
    respond(1'b0, 4'd0);
    fwd_done(16'hFFEF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
